// File: rtl/sdram_readpage_fifo_if.sv
// Handshake bundle between the SDRAM page-read capture FIFO and its neighbours.
// The master drives the write side, the read request and clear_flags. The slave returns data and status.
interface sdram_readpage_fifo_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);
   logic              wr_strobe;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   level;
   logic              page_ready;
   logic [7:0]        page_count;
   logic              overflow;
   logic              underflow;
   logic              clear_flags;

   modport master (
      output wr_strobe, wr_data, rd_en, clear_flags,
      input  rd_data, rd_valid, empty, full, level, page_ready,
             page_count, overflow, underflow
   );

   modport slave (
      input  wr_strobe, wr_data, rd_en, clear_flags,
      output rd_data, rd_valid, empty, full, level, page_ready,
             page_count, overflow, underflow
   );
endinterface

// File: rtl/sdram_readpage_fifo.sv
// Capture buffer for SDRAM full-page reads: a registered input stage feeds a two-page circular block RAM.
// A pop handshake with 1-cycle latency reads it out. Page-granular status and sticky error flags are provided.
module sdram_readpage_fifo #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 10,
   parameter int PAGE_WORDS = 512
) (
   input logic                    clk_read,
   input logic                    reset,
   sdram_readpage_fifo_if.slave   bus
);
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int LEVEL_W = ADDR_W + 1;
   localparam int PW_W    = (PAGE_WORDS > 1) ? $clog2(PAGE_WORDS) : 1;

   logic [DATA_W-1:0]  mem [0:DEPTH-1];

   logic               s_wr_reg;
   logic [DATA_W-1:0]  s_data_reg;
   logic [ADDR_W-1:0]  wp_reg;
   logic [ADDR_W-1:0]  rp_reg;
   logic [LEVEL_W-1:0] level_reg;
   logic [LEVEL_W-1:0] level_next;
   logic [PW_W-1:0]    page_word_cnt_reg;
   logic [7:0]         page_count_reg;
   logic               overflow_reg;
   logic               underflow_reg;
   logic [DATA_W-1:0]  rd_data_reg;
   logic               rd_valid_reg;

   logic               full_int;
   logic               empty_int;
   logic               wr_accept;
   logic               rd_accept;

   // Status derives from the registered level, so accept decisions use the pre-edge occupancy.
   assign full_int  = (level_reg == LEVEL_W'(DEPTH));
   assign empty_int = (level_reg == '0);
   assign wr_accept = s_wr_reg && !full_int;
   assign rd_accept = bus.rd_en && !empty_int;

   always_comb begin
      level_next = level_reg;
      case ({wr_accept, rd_accept})
         2'b10:   level_next = level_reg + LEVEL_W'(1);
         2'b01:   level_next = level_reg - LEVEL_W'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge clk_read) begin
      if (reset) begin
         s_wr_reg   <= 1'b0;
         s_data_reg <= '0;
      end else begin
         s_wr_reg   <= bus.wr_strobe;
         s_data_reg <= bus.wr_data;
      end
   end

   // The RAM array has no reset, so it maps onto a simple dual-port block RAM.
   always_ff @(posedge clk_read) begin
      if (wr_accept) begin
         mem[wp_reg] <= s_data_reg;
      end
   end

   always_ff @(posedge clk_read) begin
      if (reset) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_accept;
         if (rd_accept) begin
            rd_data_reg <= mem[rp_reg];
         end
      end
   end

   always_ff @(posedge clk_read) begin
      if (reset) begin
         wp_reg            <= '0;
         rp_reg            <= '0;
         level_reg         <= '0;
         page_word_cnt_reg <= '0;
         page_count_reg    <= '0;
      end else begin
         level_reg <= level_next;
         if (rd_accept) begin
            rp_reg <= rp_reg + ADDR_W'(1);
         end
         if (wr_accept) begin
            wp_reg <= wp_reg + ADDR_W'(1);
            if (page_word_cnt_reg == PW_W'(PAGE_WORDS - 1)) begin
               page_word_cnt_reg <= '0;
               page_count_reg    <= page_count_reg + 8'd1;
            end else begin
               page_word_cnt_reg <= page_word_cnt_reg + PW_W'(1);
            end
         end
      end
   end

   // A clear request wins over a same-cycle error event.
   always_ff @(posedge clk_read) begin
      if (reset || bus.clear_flags) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (s_wr_reg && full_int) begin
            overflow_reg <= 1'b1;
         end
         if (bus.rd_en && empty_int) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign bus.rd_data    = rd_data_reg;
   assign bus.rd_valid   = rd_valid_reg;
   assign bus.empty      = empty_int;
   assign bus.full       = full_int;
   assign bus.level      = level_reg;
   assign bus.page_ready = (level_reg >= LEVEL_W'(PAGE_WORDS));
   assign bus.page_count = page_count_reg;
   assign bus.overflow   = overflow_reg;
   assign bus.underflow  = underflow_reg;
endmodule

// File: tb/tb_sdram_readpage_fifo.sv
// Directed bench for sdram_readpage_fifo. A monitor compares every popped word against the queue of accepted words.
// Status values are hand-computed per scenario.
module tb_sdram_readpage_fifo;
   logic clk_read = 1'b0;
   logic reset    = 1'b0;

   sdram_readpage_fifo_if #(.DATA_W(16), .ADDR_W(10)) bus ();

   sdram_readpage_fifo #(.DATA_W(16), .ADDR_W(10), .PAGE_WORDS(512)) dut (
      .clk_read (clk_read),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 clk_read = ~clk_read;

   int checks   = 0;
   int failures = 0;
   int rcv_cnt  = 0;
   logic [15:0] exp_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_read);
      #1;
   endtask

   // Every valid pop must match the oldest word still expected.
   always @(posedge clk_read) begin
      #2;
      if (bus.rd_valid === 1'b1) begin
         rcv_cnt++;
         if (exp_q.size() == 0) begin
            check_val("rd_unexpected", 32'(bus.rd_valid), 32'd0);
         end else begin
            check_val("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic do_reset();
      reset           = 1'b1;
      bus.wr_strobe   = 1'b0;
      bus.rd_en       = 1'b0;
      bus.clear_flags = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      exp_q.delete();
      rcv_cnt = 0;
   endtask

   // Strobes n words base..base+n-1; only the first push_n are expected to be kept.
   task automatic write_words(input int n, input int base, input int push_n);
      for (int i = 0; i < n; i++) begin
         bus.wr_strobe = 1'b1;
         bus.wr_data   = 16'(base + i);
         if (i < push_n) exp_q.push_back(16'(base + i));
         tick();
      end
      bus.wr_strobe = 1'b0;
   endtask

   task automatic read_words(input int n);
      bus.rd_en = 1'b1;
      repeat (n) tick();
      bus.rd_en = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.wr_strobe   = 1'b0;
      bus.wr_data     = '0;
      bus.rd_en       = 1'b0;
      bus.clear_flags = 1'b0;
      do_reset();

      // Reset state
      check_val("rst_empty", 32'(bus.empty), 32'd1);
      check_val("rst_full", 32'(bus.full), 32'd0);
      check_val("rst_level", 32'(bus.level), 32'd0);
      check_val("rst_page_ready", 32'(bus.page_ready), 32'd0);
      check_val("rst_page_count", 32'(bus.page_count), 32'd0);
      check_val("rst_overflow", 32'(bus.overflow), 32'd0);
      check_val("rst_underflow", 32'(bus.underflow), 32'd0);
      check_val("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check_val("rst_rd_data", 32'(bus.rd_data), 32'd0);

      // 1: one full page in, then popped back out in order
      write_words(511, 0, 511);
      tick();
      check_val("t1_page_count_511", 32'(bus.page_count), 32'd0);
      check_val("t1_page_ready_511", 32'(bus.page_ready), 32'd0);
      write_words(1, 511, 1);
      tick();
      check_val("t1_level", 32'(bus.level), 32'd512);
      check_val("t1_page_ready", 32'(bus.page_ready), 32'd1);
      check_val("t1_page_count", 32'(bus.page_count), 32'd1);
      bus.rd_en = 1'b1;
      tick();
      check_val("t1_page_ready_fall", 32'(bus.page_ready), 32'd0);
      read_words(511);
      check_val("t1_rcv", 32'(rcv_cnt), 32'd512);
      check_val("t1_empty", 32'(bus.empty), 32'd1);
      check_val("t1_underflow", 32'(bus.underflow), 32'd0);

      // 2: 1025 strobes, last one dropped while full
      do_reset();
      write_words(1025, 16'h1000, 1024);
      tick();
      check_val("t2_full", 32'(bus.full), 32'd1);
      check_val("t2_level", 32'(bus.level), 32'd1024);
      check_val("t2_overflow", 32'(bus.overflow), 32'd1);
      check_val("t2_page_count", 32'(bus.page_count), 32'd2);
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      check_val("t2_overflow_clr", 32'(bus.overflow), 32'd0);
      read_words(1024);
      check_val("t2_rcv", 32'(rcv_cnt), 32'd1024);
      check_val("t2_empty", 32'(bus.empty), 32'd1);

      // 3: level 10, then 100 cycles of simultaneous write and pop
      do_reset();
      write_words(10, 16'h2000, 10);
      tick();
      check_val("t3_level_pre", 32'(bus.level), 32'd10);
      bus.rd_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         bus.wr_strobe = 1'b1;
         bus.wr_data   = 16'(16'h3000 + i);
         exp_q.push_back(16'(16'h3000 + i));
         tick();
      end
      bus.wr_strobe = 1'b0;
      bus.rd_en     = 1'b0;
      tick();
      tick();
      check_val("t3_level_post", 32'(bus.level), 32'd10);
      check_val("t3_rcv", 32'(rcv_cnt), 32'd100);
      check_val("t3_overflow", 32'(bus.overflow), 32'd0);
      check_val("t3_underflow", 32'(bus.underflow), 32'd0);
      read_words(10);
      check_val("t3_rcv_drain", 32'(rcv_cnt), 32'd110);
      check_val("t3_empty", 32'(bus.empty), 32'd1);

      // 4: pop while empty, clear, and clear priority over a same-cycle set
      do_reset();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      check_val("t4_rd_valid", 32'(bus.rd_valid), 32'd0);
      check_val("t4_underflow", 32'(bus.underflow), 32'd1);
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      check_val("t4_underflow_clr", 32'(bus.underflow), 32'd0);
      bus.rd_en       = 1'b1;
      bus.clear_flags = 1'b1;
      tick();
      bus.rd_en       = 1'b0;
      bus.clear_flags = 1'b0;
      check_val("t4_clear_priority", 32'(bus.underflow), 32'd0);
      check_val("t4_rcv", 32'(rcv_cnt), 32'd0);

      // 5: reset mid-page discards everything, including the word in flight
      do_reset();
      write_words(300, 16'h4000, 300);
      do_reset();
      write_words(512, 16'h5000, 512);
      tick();
      check_val("t5_level", 32'(bus.level), 32'd512);
      check_val("t5_page_count", 32'(bus.page_count), 32'd1);
      read_words(512);
      check_val("t5_rcv", 32'(rcv_cnt), 32'd512);
      check_val("t5_empty", 32'(bus.empty), 32'd1);

      // 6: 1500-word stream with 3-of-4 cycle pops, wrapping the pointers
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         bus.wr_strobe = 1'b1;
         bus.wr_data   = 16'(16'h6000 + i);
         exp_q.push_back(16'(16'h6000 + i));
         bus.rd_en     = (i >= 4) && (i % 4 != 0);
         tick();
      end
      bus.wr_strobe = 1'b0;
      bus.rd_en     = 1'b0;
      tick();
      tick();
      check_val("t6_level", 32'(bus.level), 32'(exp_q.size()));
      check_val("t6_page_count", 32'(bus.page_count), 32'd2);
      read_words(exp_q.size());
      check_val("t6_rcv", 32'(rcv_cnt), 32'd1500);
      check_val("t6_empty", 32'(bus.empty), 32'd1);
      check_val("t6_underflow", 32'(bus.underflow), 32'd0);
      check_val("t6_overflow", 32'(bus.overflow), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
